// File: rtl/uart_prog_loader.sv
`timescale 1ns/1ps
// uart_prog_loader: receives a program image over UART (8N1) and writes it
// into instruction memory one 32-bit little-endian word at a time, holding
// the processor in reset until the load completes.
//
// Image: 4-byte little-endian word count N, then 4*N data bytes.
// Optional macro LOADER_CHECKSUM_EN: a trailing byte must equal the XOR of
// all data bytes; a mismatch sends the loader to the error state.
//
// Ports:
//   w_clk        system clock
//   w_rst        asynchronous active-high reset
//   w_rxd        UART receive line (idle high, asynchronous to w_clk)
//   w_mem_we     one-cycle write strobe
//   w_mem_addr   word address of the current write
//   w_mem_wdata  write data, valid while w_mem_we=1, held between strobes
//   w_proc_rst   processor reset, released once loading finishes
//   w_done       sticky load-complete flag
//   w_err        sticky framing / oversize / checksum error flag
module uart_prog_loader #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned ADDR_W       = 11
) (
  input  logic              w_clk,
  input  logic              w_rst,
  input  logic              w_rxd,
  output logic              w_mem_we,
  output logic [ADDR_W-1:0] w_mem_addr,
  output logic [31:0]       w_mem_wdata,
  output logic              w_proc_rst,
  output logic              w_done,
  output logic              w_err
);

  localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int unsigned WCNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [32:0]      MAX_WORDS = 33'(1) << ADDR_W;

  // Two-flop synchronizer; resets to idle-high so no false start bit.
  logic rxd_meta, rxd_s;
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
    end else begin
      rxd_meta <= w_rxd;
      rxd_s    <= rxd_meta;
    end
  end

  // ---------------- UART receiver ----------------
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

  rx_state_t        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic             byte_valid_q, byte_valid_d;
  logic             frame_err_q, frame_err_d;

  // Receiver state register.
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      rx_state_q   <= RX_IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Receiver next state: half-bit start check, then centre sampling.
  always_comb begin
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q + CNT_W'(1);
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (!rxd_s) rx_state_d = RX_START;
      end
      RX_START: begin
        if (rx_cnt_q == HALF_M1) begin
          rx_cnt_d = '0;
          rx_bit_d = '0;
          // Line back high at mid start bit means it was a glitch.
          rx_state_d = rxd_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == FULL_M1) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rxd_s, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == FULL_M1) begin
          rx_cnt_d = '0;
          if (rxd_s) begin
            byte_valid_d = 1'b1;
            rx_state_d   = RX_IDLE;
          end else begin
            frame_err_d = 1'b1;
            rx_state_d  = RX_WAIT;
          end
        end
      end
      RX_WAIT: begin
        // After a bad stop bit, wait for the line to return high.
        rx_cnt_d = '0;
        if (rxd_s) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // ---------------- Loader ----------------
  typedef enum logic [2:0] {
    S_HDR,
    S_DATA,
`ifdef LOADER_CHECKSUM_EN
    S_SUM,
`endif
    S_DONE,
    S_ERR
  } ld_state_t;

`ifdef LOADER_CHECKSUM_EN
  localparam ld_state_t LAST_NEXT = S_SUM;
`else
  localparam ld_state_t LAST_NEXT = S_DONE;
`endif

  ld_state_t         st_q, st_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [WCNT_W-1:0] word_cnt_q, word_cnt_d;
  logic [WCNT_W-1:0] n_words_q, n_words_d;
  logic [23:0]       asm_q, asm_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              proc_rst_q, proc_rst_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        xor_q, xor_d;
`endif

  // Word as it would look with the current byte as its top byte.
  logic [31:0] word_c;
  assign word_c = {rx_shift_q, asm_q};

  // Loader state register.
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      st_q        <= S_HDR;
      byte_cnt_q  <= '0;
      word_cnt_q  <= '0;
      n_words_q   <= '0;
      asm_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      proc_rst_q  <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      xor_q       <= '0;
`endif
    end else begin
      st_q        <= st_d;
      byte_cnt_q  <= byte_cnt_d;
      word_cnt_q  <= word_cnt_d;
      n_words_q   <= n_words_d;
      asm_q       <= asm_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      proc_rst_q  <= proc_rst_d;
      done_q      <= done_d;
      err_q       <= err_d;
`ifdef LOADER_CHECKSUM_EN
      xor_q       <= xor_d;
`endif
    end
  end

  // Loader next state and registered outputs.
  always_comb begin
    st_d        = st_q;
    byte_cnt_d  = byte_cnt_q;
    word_cnt_d  = word_cnt_q;
    n_words_d   = n_words_q;
    asm_d       = asm_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    proc_rst_d  = (st_q != S_DONE);
    done_d      = (st_q == S_DONE);
    err_d       = err_q;
`ifdef LOADER_CHECKSUM_EN
    xor_d       = xor_q;
`endif
    // Advance after a strobe only if more words follow, so no wrap.
    if (mem_we_q && st_q == S_DATA) mem_addr_d = mem_addr_q + ADDR_W'(1);
    if (frame_err_q && st_q != S_DONE) err_d = 1'b1;
    case (st_q)
      S_HDR: begin
        if (byte_valid_q) begin
          asm_d      = word_c[31:8];
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            if (word_c == '0) begin
              st_d = LAST_NEXT;
            end else if ({1'b0, word_c} > MAX_WORDS) begin
              err_d = 1'b1;
              st_d  = S_ERR;
            end else begin
              n_words_d = WCNT_W'(word_c);
              st_d      = S_DATA;
            end
          end
        end
      end
      S_DATA: begin
        if (byte_valid_q) begin
          asm_d      = word_c[31:8];
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          xor_d      = xor_q ^ rx_shift_q;
`endif
          if (byte_cnt_q == 2'd3) begin
            mem_we_d    = 1'b1;
            mem_wdata_d = word_c;
            word_cnt_d  = word_cnt_q + WCNT_W'(1);
            if (word_cnt_q + WCNT_W'(1) == n_words_q) st_d = LAST_NEXT;
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_SUM: begin
        if (byte_valid_q) begin
          if (rx_shift_q == xor_q) begin
            st_d = S_DONE;
          end else begin
            err_d = 1'b1;
            st_d  = S_ERR;
          end
        end
      end
`endif
      S_DONE: st_d = S_DONE;
      S_ERR:  st_d = S_ERR;
      default: begin
        err_d = 1'b1;
        st_d  = S_ERR;
      end
    endcase
  end

  assign w_mem_we    = mem_we_q;
  assign w_mem_addr  = mem_addr_q;
  assign w_mem_wdata = mem_wdata_q;
  assign w_proc_rst  = proc_rst_q;
  assign w_done      = done_q;
  assign w_err       = err_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
`timescale 1ns/1ps
// Directed testbench for uart_prog_loader at CLKS_PER_BIT=8, ADDR_W=11.
module tb_uart_prog_loader;
  localparam int unsigned CPB = 8;
  localparam int unsigned AW  = 11;

  logic          w_clk = 1'b0;
  logic          w_rst = 1'b1;
  logic          w_rxd = 1'b1;
  logic          w_mem_we;
  logic [AW-1:0] w_mem_addr;
  logic [31:0]   w_mem_wdata;
  logic          w_proc_rst;
  logic          w_done;
  logic          w_err;

  uart_prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
    .w_clk(w_clk), .w_rst(w_rst), .w_rxd(w_rxd),
    .w_mem_we(w_mem_we), .w_mem_addr(w_mem_addr), .w_mem_wdata(w_mem_wdata),
    .w_proc_rst(w_proc_rst), .w_done(w_done), .w_err(w_err)
  );

  always #5 w_clk = ~w_clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cyc = -1;
  logic [AW-1:0] s_addr[$];
  logic [31:0]   s_data[$];
  int            s_cyc[$];

  // Strobe and done monitor, sampled on the falling edge.
  always @(negedge w_clk) begin
    cyc <= cyc + 1;
    if (w_mem_we) begin
      s_addr.push_back(w_mem_addr);
      s_data.push_back(w_mem_wdata);
      s_cyc.push_back(cyc);
    end
    if (w_done && done_cyc < 0) done_cyc <= cyc;
  end

  task automatic send_bit(input logic v);
    w_rxd = v;
    repeat (CPB) @(negedge w_clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
    send_bit(1'b1);
    send_bit(1'b1);
  endtask

  task automatic send4(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic settle();
    repeat (4 * CPB) @(negedge w_clk);
  endtask

  task automatic clear_log();
    s_addr.delete();
    s_data.delete();
    s_cyc.delete();
    done_cyc = -1;
  endtask

  task automatic apply_reset();
    @(negedge w_clk);
    w_rst = 1'b1;
    w_rxd = 1'b1;
    repeat (3) @(negedge w_clk);
    w_rst = 1'b0;
    clear_log();
    repeat (2) @(negedge w_clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge w_clk);
    n_checks++; if (w_mem_we !== 1'b0) begin n_fail++; $display("FAIL reset we: got %b want 0", w_mem_we); end
    n_checks++; if (w_mem_addr !== '0) begin n_fail++; $display("FAIL reset addr: got %h want 0", w_mem_addr); end
    n_checks++; if (w_mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset wdata: got %h want 0", w_mem_wdata); end
    n_checks++; if (w_proc_rst !== 1'b1) begin n_fail++; $display("FAIL reset proc_rst: got %b want 1", w_proc_rst); end
    n_checks++; if (w_done !== 1'b0) begin n_fail++; $display("FAIL reset done: got %b want 0", w_done); end
    n_checks++; if (w_err !== 1'b0) begin n_fail++; $display("FAIL reset err: got %b want 0", w_err); end
    w_rst = 1'b0;
    clear_log();
    repeat (5 * CPB) @(negedge w_clk);
    n_checks++; if (s_addr.size() != 0) begin n_fail++; $display("FAIL idle strobes: got %0d want 0", s_addr.size()); end
    n_checks++; if (w_proc_rst !== 1'b1) begin n_fail++; $display("FAIL idle proc_rst: got %b want 1", w_proc_rst); end
  endtask

  task automatic test_two_words();
    apply_reset();
    send4(32'h0000_0002);
    send4(32'h2000_0013);
    send4(32'h2000_0014);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h07, 1'b1);
`endif
    settle();
    n_checks++; if (s_addr.size() != 2) begin n_fail++; $display("FAIL two_words count: got %0d want 2", s_addr.size()); end
    if (s_addr.size() == 2) begin
      n_checks++; if (s_addr[0] !== 11'd0) begin n_fail++; $display("FAIL two_words addr0: got %h want 0", s_addr[0]); end
      n_checks++; if (s_data[0] !== 32'h2000_0013) begin n_fail++; $display("FAIL two_words data0: got %h want 20000013", s_data[0]); end
      n_checks++; if (s_addr[1] !== 11'd1) begin n_fail++; $display("FAIL two_words addr1: got %h want 1", s_addr[1]); end
      n_checks++; if (s_data[1] !== 32'h2000_0014) begin n_fail++; $display("FAIL two_words data1: got %h want 20000014", s_data[1]); end
`ifndef LOADER_CHECKSUM_EN
      n_checks++; if (done_cyc != s_cyc[1] + 1) begin n_fail++; $display("FAIL two_words done_timing: got cycle %0d want %0d", done_cyc, s_cyc[1] + 1); end
`endif
    end
    n_checks++; if (w_done !== 1'b1) begin n_fail++; $display("FAIL two_words done: got %b want 1", w_done); end
    n_checks++; if (w_proc_rst !== 1'b0) begin n_fail++; $display("FAIL two_words proc_rst: got %b want 0", w_proc_rst); end
    n_checks++; if (w_err !== 1'b0) begin n_fail++; $display("FAIL two_words err: got %b want 0", w_err); end
    n_checks++; if (w_mem_wdata !== 32'h2000_0014) begin n_fail++; $display("FAIL two_words wdata_hold: got %h want 20000014", w_mem_wdata); end
  endtask

  task automatic test_zero_count();
    apply_reset();
    send4(32'h0);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h00, 1'b1);
`endif
    settle();
    n_checks++; if (s_addr.size() != 0) begin n_fail++; $display("FAIL zero strobes: got %0d want 0", s_addr.size()); end
    n_checks++; if (w_done !== 1'b1) begin n_fail++; $display("FAIL zero done: got %b want 1", w_done); end
    n_checks++; if (w_proc_rst !== 1'b0) begin n_fail++; $display("FAIL zero proc_rst: got %b want 0", w_proc_rst); end
    n_checks++; if (w_err !== 1'b0) begin n_fail++; $display("FAIL zero err: got %b want 0", w_err); end
  endtask

  task automatic test_oversize();
    apply_reset();
    send4(32'h0000_0801);
    settle();
    n_checks++; if (w_err !== 1'b1) begin n_fail++; $display("FAIL oversize err: got %b want 1", w_err); end
    n_checks++; if (w_proc_rst !== 1'b1) begin n_fail++; $display("FAIL oversize proc_rst: got %b want 1", w_proc_rst); end
    send4(32'h1122_3344);
    send_byte(8'h00, 1'b1);
    settle();
    n_checks++; if (s_addr.size() != 0) begin n_fail++; $display("FAIL oversize strobes: got %0d want 0", s_addr.size()); end
    n_checks++; if (w_done !== 1'b0) begin n_fail++; $display("FAIL oversize done: got %b want 0", w_done); end
    n_checks++; if (w_err !== 1'b1) begin n_fail++; $display("FAIL oversize err_sticky: got %b want 1", w_err); end
  endtask

  task automatic test_max_count();
    apply_reset();
    send4(32'h0000_0800);
    settle();
    n_checks++; if (w_err !== 1'b0) begin n_fail++; $display("FAIL maxcount err: got %b want 0", w_err); end
    n_checks++; if (w_done !== 1'b0) begin n_fail++; $display("FAIL maxcount done: got %b want 0", w_done); end
    n_checks++; if (w_proc_rst !== 1'b1) begin n_fail++; $display("FAIL maxcount proc_rst: got %b want 1", w_proc_rst); end
  endtask

  task automatic test_glitch();
    apply_reset();
    w_rxd = 1'b0;
    repeat (2) @(negedge w_clk);
    w_rxd = 1'b1;
    repeat (2 * CPB) @(negedge w_clk);
    send4(32'h0000_0001);
    send4(32'h1234_5678);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h08, 1'b1);
`endif
    settle();
    n_checks++; if (s_addr.size() != 1) begin n_fail++; $display("FAIL glitch count: got %0d want 1", s_addr.size()); end
    if (s_addr.size() == 1) begin
      n_checks++; if (s_addr[0] !== 11'd0) begin n_fail++; $display("FAIL glitch addr: got %h want 0", s_addr[0]); end
      n_checks++; if (s_data[0] !== 32'h1234_5678) begin n_fail++; $display("FAIL glitch data: got %h want 12345678", s_data[0]); end
    end
    n_checks++; if (w_err !== 1'b0) begin n_fail++; $display("FAIL glitch err: got %b want 0", w_err); end
    n_checks++; if (w_done !== 1'b1) begin n_fail++; $display("FAIL glitch done: got %b want 1", w_done); end
  endtask

  task automatic test_framing_error();
    apply_reset();
    send4(32'h0000_0001);
    send_byte(8'h5A, 1'b0);
    settle();
    n_checks++; if (w_err !== 1'b1) begin n_fail++; $display("FAIL frame err: got %b want 1", w_err); end
    n_checks++; if (s_addr.size() != 0) begin n_fail++; $display("FAIL frame early_strobe: got %0d want 0", s_addr.size()); end
    send4(32'h4433_2211);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h44, 1'b1);
`endif
    settle();
    n_checks++; if (s_addr.size() != 1) begin n_fail++; $display("FAIL frame count: got %0d want 1", s_addr.size()); end
    if (s_addr.size() == 1) begin
      n_checks++; if (s_data[0] !== 32'h4433_2211) begin n_fail++; $display("FAIL frame data: got %h want 44332211", s_data[0]); end
    end
    n_checks++; if (w_done !== 1'b1) begin n_fail++; $display("FAIL frame done: got %b want 1", w_done); end
  endtask

  task automatic check_async_reset(input string tag);
    @(negedge w_clk);
    w_rst = 1'b1;
    #1;
    n_checks++; if (w_done !== 1'b0) begin n_fail++; $display("FAIL %s done: got %b want 0", tag, w_done); end
    n_checks++; if (w_err !== 1'b0) begin n_fail++; $display("FAIL %s err: got %b want 0", tag, w_err); end
    n_checks++; if (w_proc_rst !== 1'b1) begin n_fail++; $display("FAIL %s proc_rst: got %b want 1", tag, w_proc_rst); end
    n_checks++; if (w_mem_wdata !== 32'h0) begin n_fail++; $display("FAIL %s wdata: got %h want 0", tag, w_mem_wdata); end
    n_checks++; if (w_mem_addr !== '0) begin n_fail++; $display("FAIL %s addr: got %h want 0", tag, w_mem_addr); end
    repeat (3) @(negedge w_clk);
    w_rst = 1'b0;
    clear_log();
    repeat (2) @(negedge w_clk);
  endtask

  task automatic test_reset_mid();
    // Previous test leaves done/err set and wdata non-zero.
    check_async_reset("rst_after_done");
    send4(32'h0000_0001);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    check_async_reset("rst_mid_load");
    send4(32'h0000_0001);
    send4(32'hDDCC_BBAA);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h00, 1'b1);
`endif
    settle();
    n_checks++; if (s_addr.size() != 1) begin n_fail++; $display("FAIL resend count: got %0d want 1", s_addr.size()); end
    if (s_addr.size() == 1) begin
      n_checks++; if (s_addr[0] !== 11'd0) begin n_fail++; $display("FAIL resend addr: got %h want 0", s_addr[0]); end
      n_checks++; if (s_data[0] !== 32'hDDCC_BBAA) begin n_fail++; $display("FAIL resend data: got %h want ddccbbaa", s_data[0]); end
    end
    n_checks++; if (w_done !== 1'b1) begin n_fail++; $display("FAIL resend done: got %b want 1", w_done); end
    n_checks++; if (w_err !== 1'b0) begin n_fail++; $display("FAIL resend err: got %b want 0", w_err); end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum_bad();
    apply_reset();
    send4(32'h0000_0001);
    send4(32'hDDCC_BBAA);
    send_byte(8'h01, 1'b1);
    settle();
    n_checks++; if (w_err !== 1'b1) begin n_fail++; $display("FAIL csum err: got %b want 1", w_err); end
    n_checks++; if (w_done !== 1'b0) begin n_fail++; $display("FAIL csum done: got %b want 0", w_done); end
    n_checks++; if (w_proc_rst !== 1'b1) begin n_fail++; $display("FAIL csum proc_rst: got %b want 1", w_proc_rst); end
  endtask
`endif

  initial begin
    test_reset();
    test_two_words();
    test_zero_count();
    test_oversize();
    test_max_count();
    test_glitch();
    test_framing_error();
    test_reset_mid();
`ifdef LOADER_CHECKSUM_EN
    test_checksum_bad();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
- Upstream feeder for the multicycle processor's instruction memory.
- Receives a program image over a UART line and assembles bytes into 32-bit little-endian words.
- Issues one write strobe per word at incrementing word addresses.
- Holds the processor in reset until loading completes.

Parameters:
CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); must be >= 4.
ADDR_W, 11, word-address width of the target memory (2048 words).

Ports:
w_clk  input  1  system clock
w_rst  input  1  asynchronous, active-high reset
w_rxd  input  1  UART receive line, idle high, 8N1, LSB first; asynchronous to w_clk
w_mem_we  output  1  one-cycle write strobe to instruction memory
w_mem_addr  output  ADDR_W  word address of current write
w_mem_wdata  output  32  word to write; valid while w_mem_we=1
w_proc_rst  output  1  hold processor in reset; high until load completes
w_done  output  1  sticky; load finished successfully
w_err  output  1  sticky; framing error, oversize count, or checksum error

Behaviour:
- Interface: one clock, w_clk. Reset w_rst is asynchronous and active-high.
- Reset values: w_mem_we=0, w_mem_addr=0, w_mem_wdata=0, w_proc_rst=1, w_done=0, w_err=0, FSM=S_HDR, byte counter=0, word counter=0.
- Reset mid-load discards all partial state. The host must resend the whole image.
- RX front end:
  - w_rxd passes through a 2-FF synchronizer.
  - A high-to-low edge in RX_IDLE starts a bit counter.
  - At CLKS_PER_BIT/2 the line is resampled. If high, the edge is a glitch: return to RX_IDLE with no byte.
  - The 8 data bits are then sampled every CLKS_PER_BIT cycles at bit centre, LSB first.
  - The stop bit is sampled one bit period after the last data bit.
  - Stop=1: a one-cycle byte_valid pulses with the byte.
  - Stop=0: framing error. The byte is dropped and w_err is set. RX returns to idle and waits for line high before the next start.
- Frame format: 4-byte little-endian word count N, then 4*N data bytes. Each word is little-endian (first byte -> bits [7:0]).
- Loader FSM states:
  - S_HDR: collect 4 count bytes.
    - N==0 -> S_DONE.
    - N > 2**ADDR_W -> set w_err, go to S_ERR.
    - Otherwise -> S_DATA.
  - S_DATA: on each 4th byte of a word, w_mem_we=1 for exactly one cycle with the assembled word at w_mem_addr.
    - w_mem_addr increments the cycle after the strobe.
    - When the Nth word has been strobed -> S_DONE (or S_SUM, see optional feature).
    - Address never wraps; the count check guarantees this.
  - S_DONE: w_done=1, w_proc_rst=0 starting the cycle after the final strobe. All further RX bytes are ignored. No strobes.
  - S_ERR: w_proc_rst stays 1, w_err=1. Only w_rst exits.
- A framing error during S_HDR/S_DATA sets w_err but does not abort. The dropped byte shifts alignment; the host detects this via w_err.
- Byte rate is at most one per 10*CLKS_PER_BIT cycles, so no byte can arrive in the same cycle as a strobe. No backpressure exists.
- w_mem_wdata holds its last value between strobes.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - After the last data word, the FSM enters S_SUM and expects one byte equal to the XOR of all 4*N data bytes (0x00 when N==0, in which case S_HDR goes to S_SUM).
  - Match -> S_DONE. Mismatch -> set w_err, go to S_ERR.
  - The running XOR clears on reset.
- Undefined: S_SUM and the XOR logic are absent. The FSM goes directly to S_DONE after the last word.

Test Plan:
- CLKS_PER_BIT=8. Send count 02 00 00 00, then 13 00 00 20 and 14 00 00 20 -> strobes (addr 0, 0x20000013) then (addr 1, 0x20000014); w_done=1 and w_proc_rst=0 one cycle after the second strobe; w_err=0.
- Send count 00 00 00 00 (plus checksum 00 if enabled) -> no strobe; w_done=1.
- Send count 01 08 00 00 (N=2049, ADDR_W=11) -> w_err=1, w_proc_rst=1, no strobes; further bytes ignored.
- Drive a 2-cycle low glitch on w_rxd, then a valid 4-byte count 01 00 00 00 and one word -> the glitch produces no byte; one strobe at addr 0; w_err=0.
- Send a byte with stop bit 0 during S_DATA -> w_err=1; no strobe from that byte; the loader still accepts later bytes.
- Assert w_rst after 2 of 4 data bytes, then resend the full image of 1 word AABBCCDD -> all outputs return to reset values; one strobe at addr 0 with 0xDDCCBBAA. With LOADER_CHECKSUM_EN, a checksum byte of 0x01 instead of 0x00 -> w_err=1, w_done=0.
